// File: rtl/pc_gen.sv
// Fetch-stage program counter: reset vector, prioritised exception/redirect/stall,
// and a circular return-address stack for call/return prediction.
module pc_gen #(
  parameter int unsigned      XLEN       = 32,
  parameter int unsigned      INC        = 1,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter logic [XLEN-1:0]  EXC_VECTOR = XLEN'(32'h0000_0010),
  parameter int unsigned      RAS_DEPTH  = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            exc_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            call_i,
  input  logic [XLEN-1:0] call_pc_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic            ras_empty_o,
  output logic            ras_full_o
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic [PW:0]     cnt_q;
  logic [PW-1:0]   ptr_q;   // next free slot; top entry sits at ptr_q-1
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic [XLEN-1:0] pc_inc;
  logic [PW-1:0]   ptr_dec;
  logic [XLEN-1:0] top_pc;
  logic            empty;
  logic            full;
  logic            act;
  logic            ras_we;
  logic [PW-1:0]   ras_wa;

  assign pc_inc  = pc_q + XLEN'(INC);
  assign ptr_dec = ptr_q - PW'(1);
  assign top_pc  = ras_q[ptr_dec];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(RAS_DEPTH));

  // Cycles where call/ret are allowed to touch the stack
  assign act    = valid_q && !exc_i && !redirect_i && !stall_i;
  assign ras_we = act && call_i;
  assign ras_wa = (ret_i && !empty) ? ptr_dec : ptr_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else if (!valid_q) begin
      valid_q <= 1'b1;
    end else if (exc_i) begin
      pc_q  <= EXC_VECTOR;
      cnt_q <= '0;
      ptr_q <= '0;
    end else if (redirect_i) begin
      pc_q <= redirect_pc_i;
    end else if (stall_i) begin
      pc_q <= pc_q;
    end else if (call_i && ret_i && !empty) begin
      pc_q <= call_pc_i;
    end else if (call_i) begin
      pc_q  <= call_pc_i;
      ptr_q <= ptr_q + PW'(1);
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (ret_i && !empty) begin
      pc_q  <= top_pc;
      ptr_q <= ptr_dec;
      cnt_q <= cnt_q - 1'b1;
    end else begin
      pc_q <= pc_inc;
    end
  end

  // Stack contents need no reset; occupancy is tracked by cnt_q alone
  always_ff @(posedge clk_i) begin
    if (ras_we) ras_q[ras_wa] <= pc_inc;
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = valid_q;
  assign ras_empty_o = empty;
  assign ras_full_o  = full;

endmodule
